hazard_scoreboard: RTL and testbench

- Parametrised, sequential successor to the single-cycle load-use hazard unit.
- Keeps a per-register countdown scoreboard of in-flight writes with variable producer latency (ALU, load, multi-cycle mul/div).
- Each cycle, decides whether the instruction in ID must stall for RAW, branch-operand or WAW hazards.
- Sits beside the ID stage and drives the pipeline stall (PC/IF-ID hold, ID→EX bubble).

---
 rtl/hazard_scoreboard.sv | 91 +++++++++
 tb/tb_hazard_scoreboard.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register countdown of in-flight writes,
// raising RAW, branch-operand and WAW stall requests for the instruction in ID.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned REG_W       = 5,
  parameter int unsigned LAT_W       = 3,
  parameter int unsigned BR_EXTRA    = 1,
  parameter int unsigned STORE_SLACK = 1,
  parameter logic [6:0]  STORE       = 7'b0100011,
  parameter logic [6:0]  BRANCH      = 7'b1100011
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                id_valid,
  input  logic                id_flush,
  input  logic [6:0]          id_opcode,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_reg_write,
  input  logic [LAT_W-1:0]    id_latency,
  output logic                hazard,
  output logic [2:0]          hazard_cause,
  output logic [NUM_REGS-1:0] pending
);

  localparam int unsigned      CNT_W     = LAT_W + 1;
  localparam int unsigned      DEPTH     = 1 << REG_W;
  localparam logic [CNT_W-1:0] BR_LIM    = CNT_W'(BR_EXTRA);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [31:0]      STORE_LIM = 32'(BR_EXTRA + STORE_SLACK);

  // Storage spans every encodable index so lookups never go out of range;
  // entries 0 and >= NUM_REGS are held at zero.
  logic [CNT_W-1:0] cnt     [DEPTH];
  logic [CNT_W-1:0] cnt_nxt [DEPTH];

  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, wr_val;
  logic             act, issue, use1, use2, is_store, is_branch;
  logic             raw, br, waw;

  always_comb begin
    act       = id_valid & ~id_flush;
    use1      = id_use_rs1 && (id_rs1 != '0);
    use2      = id_use_rs2 && (id_rs2 != '0);
    is_store  = (id_opcode == STORE);
    is_branch = (id_opcode == BRANCH);
    cnt_rs1   = cnt[id_rs1];
    cnt_rs2   = cnt[id_rs2];
    cnt_rd    = cnt[id_rd];
    wr_val    = CNT_W'(id_latency) + BR_LIM;

    // A store's data operand is forwarded in MEM, so it tolerates extra wait.
    raw = (use1 && (cnt_rs1 > BR_LIM)) ||
          (use2 && (is_store ? (32'(cnt_rs2) > STORE_LIM) : (cnt_rs2 > BR_LIM)));
    br  = is_branch && ((use1 && (cnt_rs1 != '0)) || (use2 && (cnt_rs2 != '0)));
    waw = id_reg_write && (id_rd != '0) && (cnt_rd > wr_val);

    hazard_cause = act ? {waw, br, raw} : 3'b000;
    hazard       = |hazard_cause;
    issue        = act & ~hazard;
  end

  // A fresh issue overrides the running countdown; otherwise count down to zero.
  always_comb begin
    for (int unsigned r = 0; r < DEPTH; r++) begin
      cnt_nxt[r] = '0;
      if ((r != 0) && (r < NUM_REGS)) begin
        if (issue && id_reg_write && (id_rd == REG_W'(r)))
          cnt_nxt[r] = wr_val;
        else if (cnt[r] != '0)
          cnt_nxt[r] = cnt[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned r = 0; r < DEPTH; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) cnt[r] <= cnt_nxt[r];
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) pending[r] = (cnt[r] != '0);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios on a default instance
// plus a random held-on-stall stream on a 16-register, 4-bit-latency instance.
module tb_hazard_scoreboard;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int         BR_A      = 1;
  localparam int         BR_B      = 2;
  localparam int         SLACK     = 1;
  localparam int         MAX_STALL = 17;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid = 0, a_flush = 0, a_use_rs1 = 0, a_use_rs2 = 0, a_reg_write = 0;
  logic [6:0]  a_opcode = OP_ALU;
  logic [4:0]  a_rs1 = 0, a_rs2 = 0, a_rd = 0;
  logic [2:0]  a_latency = 0;
  logic        a_hazard;
  logic [2:0]  a_cause;
  logic [31:0] a_pending;

  logic        b_valid = 0, b_flush = 0, b_use_rs1 = 0, b_use_rs2 = 0, b_reg_write = 0;
  logic [6:0]  b_opcode = OP_ALU;
  logic [3:0]  b_rs1 = 0, b_rs2 = 0, b_rd = 0;
  logic [3:0]  b_latency = 0;
  logic        b_hazard;
  logic [2:0]  b_cause;
  logic [15:0] b_pending;

  hazard_scoreboard dut_a (
    .clk(clk), .arst_n(arst_n), .id_valid(a_valid), .id_flush(a_flush),
    .id_opcode(a_opcode), .id_rs1(a_rs1), .id_rs2(a_rs2),
    .id_use_rs1(a_use_rs1), .id_use_rs2(a_use_rs2), .id_rd(a_rd),
    .id_reg_write(a_reg_write), .id_latency(a_latency),
    .hazard(a_hazard), .hazard_cause(a_cause), .pending(a_pending)
  );

  hazard_scoreboard #(.NUM_REGS(16), .REG_W(4), .LAT_W(4), .BR_EXTRA(BR_B)) dut_b (
    .clk(clk), .arst_n(arst_n), .id_valid(b_valid), .id_flush(b_flush),
    .id_opcode(b_opcode), .id_rs1(b_rs1), .id_rs2(b_rs2),
    .id_use_rs1(b_use_rs1), .id_use_rs2(b_use_rs2), .id_rd(b_rd),
    .id_reg_write(b_reg_write), .id_latency(b_latency),
    .hazard(b_hazard), .hazard_cause(b_cause), .pending(b_pending)
  );

  int num_checks = 0;
  int num_fails  = 0;
  logic checking = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: remaining wait cycles per register, and each source's
  // tolerated wait (branch 0 for its own cause, store data BR+SLACK, else BR).
  int ma [32];
  int mb [32];

  function automatic logic [2:0] model_cause(input int c [32], input int br,
      input logic v, input logic f, input logic [6:0] op, input int rs1,
      input int rs2, input logic u1, input logic u2, input int rd,
      input logic rw, input int lat);
    logic raw = 1'b0, brh = 1'b0, waw;
    if (!v || f) return 3'b000;
    for (int k = 0; k < 2; k++) begin
      int   s   = (k == 1) ? rs2 : rs1;
      logic u   = (k == 1) ? u2 : u1;
      int   tol = (k == 1 && op == OP_STORE) ? br + SLACK : br;
      if (u && s != 0) begin
        if (c[s] > tol) raw = 1'b1;
        if (op == OP_BRANCH && c[s] > 0) brh = 1'b1;
      end
    end
    waw = rw && rd != 0 && c[rd] > lat + br;
    return {waw, brh, raw};
  endfunction

  function automatic logic [31:0] model_pending(input int c [32], input int n);
    logic [31:0] p = '0;
    for (int r = 0; r < n; r++) p[r] = (c[r] > 0);
    return p;
  endfunction

  logic [2:0] exp_a, exp_b;
  always_comb exp_a = model_cause(ma, BR_A, a_valid, a_flush, a_opcode, int'(a_rs1),
                                  int'(a_rs2), a_use_rs1, a_use_rs2, int'(a_rd),
                                  a_reg_write, int'(a_latency));
  always_comb exp_b = model_cause(mb, BR_B, b_valid, b_flush, b_opcode, int'(b_rs1),
                                  int'(b_rs2), b_use_rs1, b_use_rs2, int'(b_rd),
                                  b_reg_write, int'(b_latency));

  // Model state advance: an issued writer restarts its register's wait.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int r = 0; r < 32; r++) begin
        ma[r] <= 0;
        mb[r] <= 0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (a_valid && !a_flush && exp_a == 0 && a_reg_write && int'(a_rd) == r)
          ma[r] <= int'(a_latency) + BR_A;
        else
          ma[r] <= (ma[r] > 0) ? ma[r] - 1 : 0;
        if (r < 16 && b_valid && !b_flush && exp_b == 0 && b_reg_write && int'(b_rd) == r)
          mb[r] <= int'(b_latency) + BR_B;
        else
          mb[r] <= (mb[r] > 0) ? mb[r] - 1 : 0;
      end
    end
  end

  int   stall_run = 0;
  logic b_stalled = 1'b0;

  always @(negedge clk) begin
    if (checking && arst_n) begin
      checkOutput("a_cause",   32'(a_cause),  32'(exp_a));
      checkOutput("a_hazard",  32'(a_hazard), 32'(|exp_a));
      checkOutput("a_pending", a_pending,     model_pending(ma, 32));
      checkOutput("b_cause",   32'(b_cause),  32'(exp_b));
      checkOutput("b_hazard",  32'(b_hazard), 32'(|exp_b));
      checkOutput("b_pending", 32'(b_pending), model_pending(mb, 16));
      b_stalled = (exp_b != 0);
      stall_run = b_stalled ? stall_run + 1 : 0;
      checkOutput("b_stall_bound", 32'(stall_run > MAX_STALL), 32'd0);
    end
  end

  task automatic applyStimulus(input logic v, input logic f, input logic [6:0] op,
      input int rs1, input int rs2, input logic u1, input logic u2, input int rd,
      input logic rw, input int lat);
    @(posedge clk);
    #1;
    a_valid = v; a_flush = f; a_opcode = op;
    a_rs1 = 5'(rs1); a_rs2 = 5'(rs2); a_use_rs1 = u1; a_use_rs2 = u2;
    a_rd = 5'(rd); a_reg_write = rw; a_latency = 3'(lat);
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, OP_ALU, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic driveRandomB();
    int kind;
    @(posedge clk);
    #1;
    if (!b_stalled) begin
      kind        = $urandom_range(0, 3);
      b_rs1       = 4'($urandom_range(0, 5));
      b_rs2       = 4'($urandom_range(0, 5));
      b_rd        = 4'($urandom_range(0, 5));
      b_latency   = 4'($urandom_range(0, 15));
      b_use_rs1   = 1'b1;
      b_use_rs2   = (kind >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      b_reg_write = (kind < 2) ? ($urandom_range(0, 7) != 0) : 1'b0;
      case (kind)
        0:       b_opcode = OP_LOAD;
        1:       b_opcode = OP_ALU;
        2:       b_opcode = OP_STORE;
        default: b_opcode = OP_BRANCH;
      endcase
    end
    b_valid = ($urandom_range(0, 9) != 0);
    b_flush = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    $display("[TB] starting hazard_scoreboard bench");
    repeat (2) @(negedge clk);
    checkOutput("reset_hazard",  32'(a_hazard), 32'd0);
    checkOutput("reset_pending", a_pending,     32'd0);
    arst_n   = 1'b1;
    checking = 1'b1;

    // load x5 ; add x6,x5,x1
    applyStimulus(1, 0, OP_LOAD, 2, 0, 1, 0, 5, 1, 1);
    checkOutput("load_no_stall", 32'(a_hazard), 32'd0);
    applyStimulus(1, 0, OP_ALU, 5, 1, 1, 1, 6, 1, 0);
    checkOutput("loaduse_cause", 32'(a_cause), 32'b001);
    checkOutput("loaduse_pend1", 32'(a_pending[5]), 32'd1);
    applyStimulus(1, 0, OP_ALU, 5, 1, 1, 1, 6, 1, 0);
    checkOutput("loaduse_issue", 32'(a_hazard), 32'd0);
    checkOutput("loaduse_pend2", 32'(a_pending[5]), 32'd1);
    idle();
    checkOutput("loaduse_pend3", 32'(a_pending[5]), 32'd0);
    idle();

    // store data vs store address after a load
    applyStimulus(1, 0, OP_LOAD, 2, 0, 1, 0, 5, 1, 1);
    applyStimulus(1, 0, OP_STORE, 2, 5, 1, 1, 0, 0, 0);
    checkOutput("sw_rs2_nostall", 32'(a_hazard), 32'd0);
    idle();
    idle();
    applyStimulus(1, 0, OP_LOAD, 2, 0, 1, 0, 5, 1, 1);
    applyStimulus(1, 0, OP_STORE, 5, 7, 1, 1, 0, 0, 0);
    checkOutput("sw_rs1_cause", 32'(a_cause), 32'b001);
    applyStimulus(1, 0, OP_STORE, 5, 7, 1, 1, 0, 0, 0);
    checkOutput("sw_rs1_issue", 32'(a_hazard), 32'd0);
    idle();

    // branch operands behind ALU and load producers
    applyStimulus(1, 0, OP_IMM, 1, 0, 1, 0, 1, 1, 0);
    applyStimulus(1, 0, OP_BRANCH, 1, 2, 1, 1, 0, 0, 0);
    checkOutput("br_alu_cause", 32'(a_cause), 32'b010);
    applyStimulus(1, 0, OP_BRANCH, 1, 2, 1, 1, 0, 0, 0);
    checkOutput("br_alu_issue", 32'(a_hazard), 32'd0);
    applyStimulus(1, 0, OP_LOAD, 2, 0, 1, 0, 1, 1, 1);
    applyStimulus(1, 0, OP_BRANCH, 1, 2, 1, 1, 0, 0, 0);
    checkOutput("br_load_cause1", 32'(a_cause), 32'b011);
    applyStimulus(1, 0, OP_BRANCH, 1, 2, 1, 1, 0, 0, 0);
    checkOutput("br_load_cause2", 32'(a_cause), 32'b010);
    applyStimulus(1, 0, OP_BRANCH, 1, 2, 1, 1, 0, 0, 0);
    checkOutput("br_load_issue", 32'(a_hazard), 32'd0);

    // mul x3 then add x3: WAW ordering
    applyStimulus(1, 0, OP_ALU, 4, 4, 1, 1, 3, 1, 3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, OP_ALU, 8, 9, 1, 1, 3, 1, 0);
      checkOutput("waw_cause", 32'(a_cause), 32'b100);
    end
    applyStimulus(1, 0, OP_ALU, 8, 9, 1, 1, 3, 1, 0);
    checkOutput("waw_issue", 32'(a_hazard), 32'd0);
    idle();
    checkOutput("waw_pend1", 32'(a_pending[3]), 32'd1);
    idle();
    checkOutput("waw_pend0", 32'(a_pending[3]), 32'd0);

    // qualifiers while x5 is pending, then asynchronous reset
    applyStimulus(1, 0, OP_ALU, 4, 0, 1, 0, 5, 1, 7);
    applyStimulus(1, 0, OP_ALU, 0, 0, 1, 1, 0, 0, 0);
    checkOutput("x0_src", 32'(a_hazard), 32'd0);
    applyStimulus(1, 0, OP_ALU, 5, 5, 0, 0, 0, 0, 0);
    checkOutput("unused_src", 32'(a_hazard), 32'd0);
    applyStimulus(0, 0, OP_ALU, 5, 5, 1, 1, 7, 1, 0);
    checkOutput("invalid", 32'(a_hazard), 32'd0);
    applyStimulus(1, 1, OP_ALU, 5, 5, 1, 1, 7, 1, 0);
    checkOutput("flushed", 32'(a_hazard), 32'd0);
    checkOutput("invalid_no_update", 32'(a_pending[7]), 32'd0);
    idle();
    checkOutput("flushed_no_update", 32'(a_pending[7]), 32'd0);
    applyStimulus(1, 0, OP_ALU, 5, 0, 1, 0, 6, 1, 0);
    checkOutput("pre_reset_cause", 32'(a_cause), 32'b001);
    checkOutput("pre_reset_pend", 32'(a_pending[5]), 32'd1);
    #1 arst_n = 1'b0;
    #1;
    checkOutput("async_reset_hazard",  32'(a_hazard), 32'd0);
    checkOutput("async_reset_pending", a_pending,     32'd0);
    @(posedge clk);
    #2 arst_n = 1'b1;
    idle();

    for (int i = 0; i < 800; i++) driveRandomB();
    @(posedge clk);
    #1 b_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
